// File: rtl/ac_cool_controller_pkg.sv
// Shared types and defaults for the cooling-side climate interlock controller.
// Default widths/thresholds mirror the common climate constant set.
package ac_cool_controller_pkg;

  localparam int unsigned TEMP_W_DEF       = 8;
  localparam int unsigned COOL_ON_THR_DEF  = 26;
  localparam int unsigned COOL_OFF_THR_DEF = 24;
  localparam int unsigned STATE_W          = 2;
  localparam int unsigned STARTS_W         = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF_LOCK = 2'd0,
    ST_IDLE     = 2'd1,
    ST_COOLING  = 2'd2
  } state_e;

  typedef struct packed {
    logic want;
    logic safety_stop;
    logic comfort_stop;
  } cool_terms_t;

  function automatic logic [STARTS_W-1:0] sat_inc(input logic [STARTS_W-1:0] v);
    return (v == '1) ? v : v + STARTS_W'(1);
  endfunction

endpackage

// File: rtl/ac_cool_controller_cycle_timer.sv
// Loadable down-counter that holds at zero, with a registered zero flag.
module ac_cool_controller_cycle_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_W'(RST_VAL);
      zero_q <= (RST_VAL == 0);
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/ac_cool_controller.sv
// Compressor run controller: hysteresis, min-on, anti-short-cycle lockout, heat exclusion.
// Optional fan overrun after a stop is enabled with `define AC_COOL_FAN_OVERRUN_EN.
module ac_cool_controller
  import ac_cool_controller_pkg::*;
#(
  parameter int unsigned TEMP_W       = TEMP_W_DEF,
  parameter int unsigned COOL_ON_THR  = COOL_ON_THR_DEF,
  parameter int unsigned COOL_OFF_THR = COOL_OFF_THR_DEF,
  parameter int unsigned MIN_ON_CYC   = 8,
  parameter int unsigned MIN_OFF_CYC  = 16,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned FAN_OVR_CYC  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TEMP_W-1:0]   temp,
  input  logic                presence,
  input  logic                window,
  input  logic                heat_active,
  output logic                ac_cool,
  output logic                fan_on,
  output logic                lockout,
  output logic [STATE_W-1:0]  state,
  output logic [STARTS_W-1:0] cool_starts
);

  localparam int unsigned MAX_A   = (MIN_ON_CYC > MIN_OFF_CYC) ? MIN_ON_CYC : MIN_OFF_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > FAN_OVR_CYC) ? MAX_A : FAN_OVR_CYC;

  if (COOL_OFF_THR >= COOL_ON_THR) begin : g_thr_chk
    $error("COOL_OFF_THR must be below COOL_ON_THR");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_CYC)) begin : g_cnt_chk
    $error("CNT_W too narrow for the configured cycle counts");
  end
  if ((MIN_ON_CYC == 0) || (MIN_OFF_CYC == 0) || (FAN_OVR_CYC == 0)) begin : g_cyc_chk
    $error("cycle counts must be at least 1");
  end

  cool_terms_t           terms_c;
  state_e                state_q, state_d;
  logic                  tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]      tmr_val;
  logic                  ac_cool_q, ac_cool_d;
  logic                  fan_on_q, fan_on_d;
  logic                  lockout_q, lockout_d;
  logic [STARTS_W-1:0]   cool_starts_q, cool_starts_d;

  always_comb begin
    terms_c              = '0;
    terms_c.want         = (temp >= TEMP_W'(COOL_ON_THR)) & presence & ~window & ~heat_active;
    terms_c.safety_stop  = window | heat_active;
    terms_c.comfort_stop = (temp <= TEMP_W'(COOL_OFF_THR)) | ~presence;
  end

  // Shared lockout / min-on timer; reset value makes the power-up lockout full length.
  ac_cool_controller_cycle_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (MIN_OFF_CYC - 1)
  ) u_run_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_OFF_LOCK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = CNT_W'(MIN_OFF_CYC - 1);
    case (state_q)
      ST_OFF_LOCK: begin
        if (tmr_zero) state_d = ST_IDLE;
        else          tmr_dec = 1'b1;
      end
      ST_IDLE: begin
        if (terms_c.want) begin
          state_d  = ST_COOLING;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(MIN_ON_CYC - 1);
        end
      end
      ST_COOLING: begin
        // Safety stops bypass min-on; comfort stops wait for it to expire.
        if (terms_c.safety_stop || (terms_c.comfort_stop && tmr_zero)) begin
          state_d  = ST_OFF_LOCK;
          tmr_load = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d  = ST_OFF_LOCK;
        tmr_load = 1'b1;
      end
    endcase
  end

`ifdef AC_COOL_FAN_OVERRUN_EN
  logic leave_cool_c;
  logic ovr_q, ovr_d, ovr_load, ovr_dec, ovr_zero;

  assign leave_cool_c = (state_q == ST_COOLING) && (state_d == ST_OFF_LOCK);

  ac_cool_controller_cycle_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (0)
  ) u_ovr_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ovr_load),
    .load_val_i (CNT_W'(FAN_OVR_CYC - 1)),
    .dec_i      (ovr_dec),
    .zero_o     (ovr_zero)
  );

  // A heat-induced stop skips overrun so the fan does not fight the heater.
  always_comb begin
    ovr_d    = ovr_q;
    ovr_load = 1'b0;
    ovr_dec  = 1'b0;
    if (leave_cool_c && !heat_active) begin
      ovr_d    = 1'b1;
      ovr_load = 1'b1;
    end else if (ovr_q) begin
      if (ovr_zero) ovr_d   = 1'b0;
      else          ovr_dec = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end
`endif

  always_comb begin
    ac_cool_d     = (state_d == ST_COOLING);
    lockout_d     = (state_d == ST_OFF_LOCK);
    cool_starts_d = cool_starts_q;
    if ((state_q == ST_IDLE) && (state_d == ST_COOLING)) begin
      cool_starts_d = sat_inc(cool_starts_q);
    end
`ifdef AC_COOL_FAN_OVERRUN_EN
    fan_on_d = ac_cool_d | ovr_d;
`else
    fan_on_d = ac_cool_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_cool_q     <= 1'b0;
      fan_on_q      <= 1'b0;
      lockout_q     <= 1'b1;
      cool_starts_q <= '0;
    end else begin
      ac_cool_q     <= ac_cool_d;
      fan_on_q      <= fan_on_d;
      lockout_q     <= lockout_d;
      cool_starts_q <= cool_starts_d;
    end
  end

  assign ac_cool     = ac_cool_q;
  assign fan_on      = fan_on_q;
  assign lockout     = lockout_q;
  assign state       = state_q;
  assign cool_starts = cool_starts_q;

endmodule

// File: tb/tb_ac_cool_controller.sv
// Scoreboard bench for ac_cool_controller: directed stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_ac_cool_controller;

`ifdef AC_COOL_FAN_OVERRUN_EN
  localparam bit FOVR = 1'b1;
`else
  localparam bit FOVR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  temp;
  logic        presence;
  logic        window;
  logic        heat_active;
  logic        ac_cool;
  logic        fan_on;
  logic        lockout;
  logic [1:0]  state;
  logic [15:0] cool_starts;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int          q_cyc[$];
  logic [20:0] q_val[$];
  string       q_name[$];

  ac_cool_controller dut (
    .clk         (clk),
    .rst         (rst),
    .temp        (temp),
    .presence    (presence),
    .window      (window),
    .heat_active (heat_active),
    .ac_cool     (ac_cool),
    .fan_on      (fan_on),
    .lockout     (lockout),
    .state       (state),
    .cool_starts (cool_starts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input logic ac, input logic fan, input logic lk,
                            input logic [1:0] st, input logic [15:0] starts, input string name);
    q_cyc.push_back(cyc);
    q_val.push_back({ac, fan, lk, st, starts});
    q_name.push_back(name);
  endtask

  // Monitor: compare every expectation due in the current cycle
  initial begin
    logic [20:0] got, exp_v;
    string       nm;
    forever begin
      @(negedge clk);
      while ((q_cyc.size() > 0) && (q_cyc[0] <= cyc)) begin
        void'(q_cyc.pop_front());
        exp_v = q_val.pop_front();
        nm    = q_name.pop_front();
        got   = {ac_cool, fan_on, lockout, state, cool_starts};
        n_cmp++;
        if (got !== exp_v) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got ac=%b fan=%b lk=%b st=%0d starts=%0d want ac=%b fan=%b lk=%b st=%0d starts=%0d",
                   nm, cyc, got[20], got[19], got[18], got[17:16], got[15:0],
                   exp_v[20], exp_v[19], exp_v[18], exp_v[17:16], exp_v[15:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; temp = 8'd30; presence = 1'b1; window = 1'b0; heat_active = 1'b0;
    go(2);
    expect_now(0, 0, 1, 2'd0, 16'd0, "reset");
    rst = 1'b0;
    expect_now(0, 0, 1, 2'd0, 16'd0, "lock_start");
    go(15); expect_now(0, 0, 1, 2'd0, 16'd0, "lock_end");
    go(1);  expect_now(0, 0, 0, 2'd1, 16'd0, "idle");
    go(1);  expect_now(1, 1, 0, 2'd2, 16'd1, "cool_on");

    // Hysteresis once min-on has expired
    go(8);  temp = 8'd25;
    go(1);  expect_now(1, 1, 0, 2'd2, 16'd1, "hyst_band");
    go(2);  expect_now(1, 1, 0, 2'd2, 16'd1, "hyst_band2");
    temp = 8'd24;
    go(1);  expect_now(0, FOVR, 1, 2'd0, 16'd1, "hyst_off");
    go(3);  expect_now(0, FOVR, 1, 2'd0, 16'd1, "ovr_hold");
    go(1);  expect_now(0, 0, 1, 2'd0, 16'd1, "ovr_end");
    temp = 8'd30;
    go(12); expect_now(0, 0, 0, 2'd1, 16'd1, "idle2");
    go(1);  expect_now(1, 1, 0, 2'd2, 16'd2, "cool2");

    // Min-on hold: comfort stop arrives on 3rd cooling cycle
    go(2);  temp = 8'd20;
    go(5);  expect_now(1, 1, 0, 2'd2, 16'd2, "minon_hold");
    go(1);  expect_now(0, FOVR, 1, 2'd0, 16'd2, "minon_off");
    temp = 8'd30;
    go(16); expect_now(0, 0, 0, 2'd1, 16'd2, "idle3");
    go(1);  expect_now(1, 1, 0, 2'd2, 16'd3, "cool3");

    // Window safety stop during min-on
    go(1);  window = 1'b1;
    go(1);  expect_now(0, FOVR, 1, 2'd0, 16'd3, "safety_off");
    window = 1'b0;
    go(3);  expect_now(0, FOVR, 1, 2'd0, 16'd3, "win_ovr");
    go(1);  expect_now(0, 0, 1, 2'd0, 16'd3, "win_ovr_end");
    go(11); expect_now(0, 0, 1, 2'd0, 16'd3, "win_lock_end");
    go(1);  expect_now(0, 0, 0, 2'd1, 16'd3, "win_idle");
    go(1);  expect_now(1, 1, 0, 2'd2, 16'd4, "cool4");

    // Heat exclusion: stop without overrun, then blocked restart
    go(1);  heat_active = 1'b1;
    go(1);  expect_now(0, 0, 1, 2'd0, 16'd4, "heat_stop");
    go(16); expect_now(0, 0, 0, 2'd1, 16'd4, "heat_idle");
    go(3);  expect_now(0, 0, 0, 2'd1, 16'd4, "heat_excl");
    heat_active = 1'b0;
    go(1);  expect_now(1, 1, 0, 2'd2, 16'd5, "heat_release");

    // Asynchronous reset mid-cooling, checked before the next clock edge
    go(2);  expect_now(1, 1, 0, 2'd2, 16'd5, "pre_rst");
    go(1);  rst = 1'b1;
    expect_now(0, 0, 1, 2'd0, 16'd0, "async_rst");
    go(1);  expect_now(0, 0, 1, 2'd0, 16'd0, "rst_hold");
    rst = 1'b0;

    for (int i = 0; (i < 8) && (q_cyc.size() > 0); i++) @(negedge clk);
    #1;
    if (q_cyc.size() != 0) begin
      $display("FAIL drain pending=%0d want 0", q_cyc.size());
      n_bad += q_cyc.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
